// File: rtl/writeback_arbiter_pkg.sv
// Shared definitions for the write-back arbiter: default widths, the
// buffered EXU entry layout and the grant-source encoding.
package writeback_arbiter_pkg;

    localparam int WB_DATA_W       = 32;
    localparam int WB_ADDR_W       = 5;
    localparam int WB_STARVE_LIMIT = 4;

    // One buffered EXU write-back at the default widths.
    typedef struct packed {
        logic [WB_ADDR_W-1:0] addr;
        logic [WB_DATA_W-1:0] data;
        logic                 ret;
    } wbEntry_t;

    // Which requester owns the register-file write port this cycle.
    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_LD   = 2'd1,
        GNT_EX   = 2'd2
    } gntSrc_e;

endpackage

// File: rtl/wb_skid_fifo.sv
// Two-entry FIFO holding EXU write-back entries until the arbiter grants them.
// Full/empty are decoded from registered occupancy only; a push while full is
// dropped even if a pop happens in the same cycle.
module wb_skid_fifo #(
    parameter int WIDTH = 38
) (
    input  logic             iClk,
    input  logic             iRst_n,
    input  logic             iPush,
    input  logic [WIDTH-1:0] iData,
    input  logic             iPop,
    output logic [WIDTH-1:0] oHead,
    output logic             oFull,
    output logic             oEmpty
);

    logic [WIDTH-1:0] mem_r [2];
    logic             wrPtr_r;
    logic             rdPtr_r;
    logic [1:0]       count_r;
    logic             pushOk_s;
    logic             popOk_s;

    assign oFull    = (count_r == 2'd2);
    assign oEmpty   = (count_r == 2'd0);
    assign pushOk_s = iPush && !oFull;
    assign popOk_s  = iPop && !oEmpty;
    assign oHead    = mem_r[rdPtr_r];

    // Storage, pointers and occupancy; reset flushes all buffered entries.
    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            mem_r[0] <= {WIDTH{1'b0}};
            mem_r[1] <= {WIDTH{1'b0}};
            wrPtr_r  <= 1'b0;
            rdPtr_r  <= 1'b0;
            count_r  <= 2'd0;
        end else begin
            if (pushOk_s) begin
                mem_r[wrPtr_r] <= iData;
                wrPtr_r        <= ~wrPtr_r;
            end
            if (popOk_s) begin
                rdPtr_r <= ~rdPtr_r;
            end
            count_r <= count_r + {1'b0, pushOk_s} - {1'b0, popOk_s};
        end
    end

endmodule

// File: rtl/writeback_arbiter.sv
// Register-file write-back arbiter between an unbuffered load port and a
// buffered EXU port, with an anti-starvation counter protecting EXU entries.
// Optional feature: define WB_ARB_RETINC_EN to write data+1 for EXU entries
// flagged as return-address commands.
module writeback_arbiter
    import writeback_arbiter_pkg::*;
#(
    parameter int DATA_W       = WB_DATA_W,
    parameter int ADDR_W       = WB_ADDR_W,
    parameter int STARVE_LIMIT = WB_STARVE_LIMIT
) (
    input  logic              iClk,
    input  logic              iRst_n,
    input  logic              iLdValid,
    input  logic [ADDR_W-1:0] iLdAddr,
    input  logic [DATA_W-1:0] iLdData,
    output logic              oLdReady,
    input  logic              iExValid,
    input  logic [ADDR_W-1:0] iExAddr,
    input  logic [DATA_W-1:0] iExData,
    input  logic              iExRet,
    output logic              oExReady,
    output logic              oWrEn,
    output logic [ADDR_W-1:0] oWrAddr,
    output logic [DATA_W-1:0] oWrData
);

`ifdef WB_ARB_RETINC_EN
    localparam int RET_W = 1;
`else
    localparam int RET_W = 0;
`endif
    localparam int ENT_W = ADDR_W + DATA_W + RET_W;
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

    gntSrc_e           gnt_s;
    logic [CNT_W-1:0]  starve_r;
    logic              fifoFull_s;
    logic              fifoEmpty_s;
    logic              exPush_s;
    logic [ENT_W-1:0]  pushEntry_s;
    logic [ENT_W-1:0]  fifoHead_s;
    logic [ADDR_W-1:0] headAddr_s;
    logic [DATA_W-1:0] headData_s;
    logic [DATA_W-1:0] wrDataEx_s;

    assign oExReady   = !fifoFull_s;
    assign exPush_s   = iExValid && !fifoFull_s;
    assign headAddr_s = fifoHead_s[ENT_W-1 -: ADDR_W];
    assign headData_s = fifoHead_s[ENT_W-ADDR_W-1 -: DATA_W];

`ifdef WB_ARB_RETINC_EN
    logic headRet_s;
    assign pushEntry_s = {iExAddr, iExData, iExRet};
    assign headRet_s   = fifoHead_s[0];
    assign wrDataEx_s  = headData_s + {{(DATA_W-1){1'b0}}, headRet_s};
`else
    logic unusedRet_s;
    assign unusedRet_s = iExRet;
    assign pushEntry_s = {iExAddr, iExData};
    assign wrDataEx_s  = headData_s;
`endif

    wb_skid_fifo #(
        .WIDTH (ENT_W)
    ) uFifo (
        .iClk   (iClk),
        .iRst_n (iRst_n),
        .iPush  (exPush_s),
        .iData  (pushEntry_s),
        .iPop   (gnt_s == GNT_EX),
        .oHead  (fifoHead_s),
        .oFull  (fifoFull_s),
        .oEmpty (fifoEmpty_s)
    );

    // Single grant per cycle: a starved EXU entry beats loads, otherwise loads win.
    always_comb begin
        gnt_s    = GNT_NONE;
        oLdReady = 1'b0;
        if (!fifoEmpty_s && (starve_r == LIMIT_C)) begin
            gnt_s = GNT_EX;
        end else if (iLdValid) begin
            gnt_s    = GNT_LD;
            oLdReady = 1'b1;
        end else if (!fifoEmpty_s) begin
            gnt_s = GNT_EX;
        end else begin
            gnt_s = GNT_NONE;
        end
    end

    // Count load grants that overtake a waiting EXU entry, saturating at the limit.
    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            starve_r <= {CNT_W{1'b0}};
        end else if (fifoEmpty_s || (gnt_s == GNT_EX)) begin
            starve_r <= {CNT_W{1'b0}};
        end else if ((gnt_s == GNT_LD) && (starve_r != LIMIT_C)) begin
            starve_r <= starve_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            starve_r <= starve_r;
        end
    end

    // Register the granted entry onto the write port; address 0 never writes.
    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            oWrEn   <= 1'b0;
            oWrAddr <= {ADDR_W{1'b0}};
            oWrData <= {DATA_W{1'b0}};
        end else begin
            case (gnt_s)
                GNT_LD: begin
                    oWrEn   <= (iLdAddr != {ADDR_W{1'b0}});
                    oWrAddr <= iLdAddr;
                    oWrData <= iLdData;
                end
                GNT_EX: begin
                    oWrEn   <= (headAddr_s != {ADDR_W{1'b0}});
                    oWrAddr <= headAddr_s;
                    oWrData <= wrDataEx_s;
                end
                default: begin
                    oWrEn <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Self-checking bench for writeback_arbiter: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a
// queue-based model of the arbitration rules.
module tb_writeback_arbiter;

    localparam int LIMIT  = 4;
    localparam int G_NONE = 0;
    localparam int G_LD   = 1;
    localparam int G_EX   = 2;

    logic        clk = 1'b0;
    logic        iRst_n = 1'b0;
    logic        iLdValid = 1'b0;
    logic [4:0]  iLdAddr = 5'd0;
    logic [31:0] iLdData = 32'd0;
    logic        oLdReady;
    logic        iExValid = 1'b0;
    logic [4:0]  iExAddr = 5'd0;
    logic [31:0] iExData = 32'd0;
    logic        iExRet = 1'b0;
    logic        oExReady;
    logic        oWrEn;
    logic [4:0]  oWrAddr;
    logic [31:0] oWrData;

    writeback_arbiter dut (
        .iClk     (clk),
        .iRst_n   (iRst_n),
        .iLdValid (iLdValid),
        .iLdAddr  (iLdAddr),
        .iLdData  (iLdData),
        .oLdReady (oLdReady),
        .iExValid (iExValid),
        .iExAddr  (iExAddr),
        .iExData  (iExData),
        .iExRet   (iExRet),
        .oExReady (oExReady),
        .oWrEn    (oWrEn),
        .oWrAddr  (oWrAddr),
        .oWrData  (oWrData)
    );

    always #5 clk = ~clk;

    int nChecks = 0;
    int nFails  = 0;
    bit checkOn = 1'b0;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
        logic        ret;
    } mEntry_t;

    mEntry_t     q[$];
    int          starve = 0;
    logic        expWrEn = 1'b0;
    logic [4:0]  expAddr = 5'd0;
    logic [31:0] expData = 32'd0;
    bit          addrKnown = 1'b1;

`ifdef WB_ARB_RETINC_EN
    localparam logic [31:0] EXP34 = 32'h0000_0011;
`else
    localparam logic [31:0] EXP34 = 32'h0000_0010;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int modelGrant();
        if (starve == LIMIT && q.size() > 0) return G_EX;
        if (iLdValid) return G_LD;
        if (q.size() > 0) return G_EX;
        return G_NONE;
    endfunction

    // Reference model: advances on every rising edge from the inputs held that cycle.
    initial begin
        forever begin
            int      g;
            bit      wasEmpty;
            bit      pushOk;
            mEntry_t e;
            @(posedge clk);
            if (!iRst_n) begin
                q.delete();
                starve    = 0;
                expWrEn   = 1'b0;
                expAddr   = 5'd0;
                expData   = 32'd0;
                addrKnown = 1'b1;
            end else begin
                g        = modelGrant();
                wasEmpty = (q.size() == 0);
                pushOk   = iExValid && (q.size() < 2);
                if (g == G_LD) begin
                    expWrEn   = (iLdAddr != 5'd0);
                    expAddr   = iLdAddr;
                    expData   = iLdData;
                    addrKnown = expWrEn;
                end else if (g == G_EX) begin
                    e       = q.pop_front();
                    expWrEn = (e.addr != 5'd0);
                    expAddr = e.addr;
`ifdef WB_ARB_RETINC_EN
                    expData = e.data + (e.ret ? 32'd1 : 32'd0);
`else
                    expData = e.data;
`endif
                    addrKnown = expWrEn;
                end else begin
                    expWrEn = 1'b0;
                end
                if (wasEmpty || g == G_EX) starve = 0;
                else if (g == G_LD && starve < LIMIT) starve = starve + 1;
                if (pushOk) begin
                    e.addr = iExAddr;
                    e.data = iExData;
                    e.ret  = iExRet;
                    q.push_back(e);
                end
            end
        end
    end

    // Compare process: every falling edge, DUT outputs against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (checkOn) begin
                chk("cmp_ldReady", {31'd0, oLdReady}, {31'd0, modelGrant() == G_LD});
                chk("cmp_exReady", {31'd0, oExReady}, {31'd0, q.size() < 2});
                chk("cmp_wrEn", {31'd0, oWrEn}, {31'd0, expWrEn});
                if (expWrEn || addrKnown) begin
                    chk("cmp_wrAddr", {27'd0, oWrAddr}, {27'd0, expAddr});
                    chk("cmp_wrData", oWrData, expData);
                end
            end
        end
    end

    task automatic setIn(input logic lv, input logic [4:0] la, input logic [31:0] ld,
                         input logic ev, input logic [4:0] ea, input logic [31:0] ed,
                         input logic er);
        @(posedge clk);
        #2;
        iLdValid = lv; iLdAddr = la; iLdData = ld;
        iExValid = ev; iExAddr = ea; iExData = ed; iExRet = er;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) setIn(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    endtask

    initial begin
        int ldWait;
        int exAt;
        int heldCyc;
        bit accepted;
        bit resumed;

        // Reset and reset-state checks.
        idle(3);
        @(posedge clk); #2; iRst_n = 1'b1;
        checkOn = 1'b1;
        settle();
        chk("rst_exReady", {31'd0, oExReady}, 32'd1);
        chk("rst_wrEn", {31'd0, oWrEn}, 32'd0);
        chk("rst_wrAddr", {27'd0, oWrAddr}, 32'd0);
        chk("rst_wrData", oWrData, 32'd0);

        // Single load.
        setIn(1'b1, 5'd3, 32'h0000_00AA, 1'b0, 5'd0, 32'd0, 1'b0);
        settle();
        chk("ld_ready", {31'd0, oLdReady}, 32'd1);
        idle(1); settle();
        chk("ld_wrEn", {31'd0, oWrEn}, 32'd1);
        chk("ld_wrAddr", {27'd0, oWrAddr}, 32'd3);
        chk("ld_wrData", oWrData, 32'h0000_00AA);

        // Single EXU push with ret set.
        idle(2);
        setIn(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h0000_0010, 1'b1);
        settle();
        chk("ex_ready", {31'd0, oExReady}, 32'd1);
        idle(1); settle();
        chk("ex_wrEn_early", {31'd0, oWrEn}, 32'd0);
        idle(1); settle();
        chk("ex_wrEn", {31'd0, oWrEn}, 32'd1);
        chk("ex_wrAddr", {27'd0, oWrAddr}, 32'd5);
        chk("ex_wrData", oWrData, EXP34);

        // Starvation limit under a continuous load stream.
        idle(2);
        setIn(1'b1, 5'd1, 32'h100, 1'b1, 5'd9, 32'h99, 1'b0);
        settle();
        chk("starve_first_ld", {31'd0, oLdReady}, 32'd1);
        ldWait = 0; exAt = -1; resumed = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            setIn(1'b1, 5'(i + 1), 32'h100 + i, 1'b0, 5'd0, 32'd0, 1'b0);
            settle();
            if (exAt < 0) begin
                if (oLdReady) ldWait++;
                else exAt = i;
            end else if (i == exAt + 1) begin
                resumed = oLdReady;
            end
        end
        chk("starve_ld_grants", ldWait, 32'd4);
        chk("starve_ex_cycle", exAt, 32'd5);
        chk("starve_resume", {31'd0, resumed}, 32'd1);

        // Three back-to-back pushes under loads: third waits for a free slot.
        idle(3);
        setIn(1'b1, 5'd2, 32'h20, 1'b1, 5'd10, 32'hA0, 1'b0);
        settle();
        chk("full_ready0", {31'd0, oExReady}, 32'd1);
        setIn(1'b1, 5'd3, 32'h21, 1'b1, 5'd11, 32'hA1, 1'b0);
        settle();
        chk("full_ready1", {31'd0, oExReady}, 32'd1);
        setIn(1'b1, 5'd4, 32'h22, 1'b1, 5'd12, 32'hA2, 1'b0);
        settle();
        chk("full_ready2", {31'd0, oExReady}, 32'd0);
        heldCyc = 0; accepted = 1'b0;
        for (int i = 0; i < 20 && !accepted; i++) begin
            setIn(1'b1, 5'd4, 32'h40 + i, 1'b1, 5'd12, 32'hA2, 1'b0);
            settle();
            if (oExReady) accepted = 1'b1;
            else heldCyc++;
        end
        chk("full_accepted", {31'd0, accepted}, 32'd1);
        chk("full_held", heldCyc, 32'd3);
        idle(10);

        // Load to address 0: handshake but no write.
        setIn(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0, 32'd0, 1'b0);
        settle();
        chk("zero_ready", {31'd0, oLdReady}, 32'd1);
        idle(1); settle();
        chk("zero_wrEn", {31'd0, oWrEn}, 32'd0);

        // Reset with two EXU entries buffered and a load write pending.
        idle(2);
        setIn(1'b1, 5'd1, 32'h11, 1'b1, 5'd7, 32'h1, 1'b0);
        setIn(1'b1, 5'd2, 32'h22, 1'b1, 5'd8, 32'h2, 1'b0);
        @(posedge clk); #2;
        iRst_n = 1'b0; iLdValid = 1'b0; iExValid = 1'b0;
        settle();
        chk("mrst_pre_full", {31'd0, oExReady}, 32'd0);
        @(posedge clk); #2; iRst_n = 1'b1;
        settle();
        chk("mrst_exReady", {31'd0, oExReady}, 32'd1);
        chk("mrst_wrEn", {31'd0, oWrEn}, 32'd0);
        chk("mrst_wrAddr", {27'd0, oWrAddr}, 32'd0);
        chk("mrst_wrData", oWrData, 32'd0);
        for (int i = 0; i < 5; i++) begin
            idle(1); settle();
            chk("mrst_no_write", {31'd0, oWrEn}, 32'd0);
        end

        // Randomized traffic, checked by the compare process each cycle.
        for (int i = 0; i < 1500; i++) begin
            @(posedge clk); #2;
            iRst_n   = ($urandom_range(0, 99) != 0);
            iLdValid = ($urandom_range(0, 99) < 60);
            iLdAddr  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            iLdData  = $urandom;
            iExValid = ($urandom_range(0, 99) < 45);
            iExAddr  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            iExData  = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFF : 32'($urandom);
            iExRet   = $urandom_range(0, 1);
        end
        @(posedge clk); #2; iRst_n = 1'b1;
        idle(12);
        settle();

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
